// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment lookup for the seven-segment scan driver.
package seg7_pkg;

  localparam int unsigned SEG_W    = 8;
  localparam int unsigned NIBBLE_W = 4;

  localparam logic [SEG_W-1:0] SEG_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns, entry 15 first down to entry 0.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [NIBBLE_W-1:0] nibble);
    return HEX_SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [6:0]          seg_c
);

  assign seg_c = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit time-multiplexed seven-segment scanner with shadow/frame buffering.
// Optional leading-zero suppression when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic [NIBBLE_W*DIGITS-1:0]   data_in,
  input  logic                         load,
  input  logic [DIGITS-1:0]            dp_in,
  input  logic [DIGITS-1:0]            blank_mask,
  output logic [SEG_W-1:0]             SEG,
  output logic [DIGITS-1:0]            AN,
  output logic                         frame_done
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0]                    div_cnt;
  logic [IDX_W-1:0]                    dig_idx;
  logic [DIGITS-1:0][NIBBLE_W-1:0]     shadow_data;
  logic [DIGITS-1:0][NIBBLE_W-1:0]     frame_data;
  logic [DIGITS-1:0]                   shadow_dp;
  logic [DIGITS-1:0]                   frame_dp;

  logic                                tick_c;
  logic                                last_dig_c;
  logic                                wrap_c;
  logic                                blank_c;
  logic [NIBBLE_W-1:0]                 nibble_c;
  logic [6:0]                          hex_seg_c;
  logic [DIGITS-1:0]                   lz_blank_c;
  logic [DIGITS-1:0]                   an_nxt_c;
  logic [SEG_W-1:0]                    seg_nxt_c;

  assign tick_c     = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign last_dig_c = (dig_idx == IDX_W'(DIGITS - 1));
  assign wrap_c     = tick_c && last_dig_c;
  assign nibble_c   = frame_data[dig_idx];

  seg7_hex_decode u_hex_decode (
    .nibble (nibble_c),
    .seg_c  (hex_seg_c)
  );

`ifdef SEG7_LZ_BLANK_EN
  logic lz_run_c;

  // Digit i is suppressed while every nibble from the top down to i is zero.
  always_comb begin
    lz_blank_c = '0;
    lz_run_c   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run_c      = lz_run_c && (frame_data[i] == 4'h0);
      lz_blank_c[i] = lz_run_c;
    end
  end
`else
  assign lz_blank_c = '0;
`endif

  // Next registered pin values for the digit currently selected.
  always_comb begin
    blank_c   = blank_mask[dig_idx] | lz_blank_c[dig_idx];
    an_nxt_c  = ~(DIGITS'(1) << dig_idx);
    seg_nxt_c = {~frame_dp[dig_idx], hex_seg_c};
    if (blank_c) begin
      an_nxt_c  = '1;
      seg_nxt_c = SEG_OFF;
    end
  end

  // Scan divider and digit pointer.
  always_ff @(posedge clk) begin
    if (RST) begin
      div_cnt <= '0;
      dig_idx <= '0;
    end else begin
      div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
      if (tick_c) begin
        dig_idx <= last_dig_c ? '0 : dig_idx + IDX_W'(1);
      end
    end
  end

  // Shadow captures on load; frame copies the pre-edge shadow only at the frame wrap.
  always_ff @(posedge clk) begin
    if (RST) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      frame_data  <= '0;
      frame_dp    <= '0;
    end else begin
      if (load) begin
        shadow_data <= data_in;
        shadow_dp   <= dp_in;
      end
      if (wrap_c) begin
        frame_data <= shadow_data;
        frame_dp   <= shadow_dp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      AN         <= '1;
      SEG        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      AN         <= an_nxt_c;
      SEG        <= seg_nxt_c;
      frame_done <= wrap_c;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl (DIGITS=8, SCAN_DIV=4).
module tb_seg7_scan_ctrl;

  localparam int unsigned DIGITS   = 8;
  localparam int unsigned SCAN_DIV = 4;
`ifdef SEG7_LZ_BLANK_EN
  localparam logic [7:0] LZ_MASK = 8'h80;
`else
  localparam logic [7:0] LZ_MASK = 8'h00;
`endif

  logic        clk;
  logic        RST;
  logic [31:0] data_in;
  logic        load;
  logic [7:0]  dp_in;
  logic [7:0]  blank_mask;
  logic [7:0]  SEG;
  logic [7:0]  AN;
  logic        frame_done;

  int vectors;
  int errors;

  seg7_scan_ctrl #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .data_in    (data_in),
    .load       (load),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .SEG        (SEG),
    .AN         (AN),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one 32-cycle frame; optional loads mid-frame (edge 16) and on the wrap edge (32).
  task automatic run_frame(input string name, input logic [7:0][7:0] exp_seg,
                           input logic [7:0] exp_blank,
                           input bit mid_en, input logic [31:0] mid_data,
                           input bit wrap_en, input logic [31:0] wrap_data);
    int d;
    logic [7:0] exp_an;
    logic [7:0] exp_sg;
    for (int c = 1; c <= 32; c++) begin
      step();
      load = 1'b0;
      if (mid_en && c == 15) begin
        data_in = mid_data;
        load    = 1'b1;
      end
      if (wrap_en && c == 31) begin
        data_in = wrap_data;
        load    = 1'b1;
      end
      d      = (c - 1) / 4;
      exp_an = exp_blank[d] ? 8'hFF : ~(8'h01 << d);
      exp_sg = exp_blank[d] ? 8'hFF : exp_seg[d];
      check_vec($sformatf("%s_an_c%0d", name, c), {24'h0, AN}, {24'h0, exp_an});
      check_vec($sformatf("%s_seg_c%0d", name, c), {24'h0, SEG}, {24'h0, exp_sg});
      check_vec($sformatf("%s_fd_c%0d", name, c), {31'h0, frame_done}, {31'h0, (c == 32)});
    end
  endtask

  logic [7:0][7:0] seg_t2;
  logic [7:0][7:0] seg_t3;
  logic [7:0][7:0] seg_ones;
  logic [7:0][7:0] seg_twos;
  int n;

  initial begin
    vectors    = 0;
    errors     = 0;
    RST        = 1'b1;
    load       = 1'b0;
    data_in    = '0;
    dp_in      = '0;
    blank_mask = '0;

    // 0123_89AB: digit0..7 = B,A,9,8,3,2,1,0
    seg_t2   = {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h80, 8'h90, 8'h88, 8'h83};
    seg_t3   = {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h80, 8'h10, 8'h88, 8'h83};
    seg_ones = {8{8'hF9}};
    seg_twos = {8{8'hA4}};

    // Reset holds outputs idle.
    for (int r = 0; r < 3; r++) begin
      step();
      check_vec("rst_an", {24'h0, AN}, 32'hFF);
      check_vec("rst_seg", {24'h0, SEG}, 32'hFF);
      check_vec("rst_fd", {31'h0, frame_done}, 32'h0);
    end
    RST = 1'b0;
    step();
    check_vec("first_an", {24'h0, AN}, 32'hFE);
    check_vec("first_seg", {24'h0, SEG}, 32'hC0);

    // Load data, wait for first frame boundary (31 more edges).
    data_in = 32'h0123_89AB;
    dp_in   = 8'h00;
    load    = 1'b1;
    n = 0;
    while (!frame_done && n < 64) begin
      step();
      load = 1'b0;
      n++;
    end
    check_vec("first_fd_cycles", n, 31);

    // Frame with the loaded value; dp for digit 2 enters the shadow at its start.
    dp_in = 8'h04;
    load  = 1'b1;
    run_frame("t2", seg_t2, LZ_MASK, 1'b0, '0, 1'b0, '0);
    run_frame("t3", seg_t3, LZ_MASK, 1'b0, '0, 1'b0, '0);

    // Live blanking of digit 7.
    blank_mask = 8'h80;
    run_frame("t4a", seg_t3, 8'h80, 1'b0, '0, 1'b0, '0);
    run_frame("t4b", seg_t3, 8'h80, 1'b0, '0, 1'b0, '0);
    blank_mask = 8'h00;

    // Mid-frame load shows next frame; wrap-edge load is delayed one more frame.
    dp_in = 8'h00;
    run_frame("t5a", seg_t3, LZ_MASK, 1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222);
    run_frame("t5b", seg_ones, 8'h00, 1'b0, '0, 1'b0, '0);
    run_frame("t5c", seg_twos, 8'h00, 1'b0, '0, 1'b0, '0);

    // Advance into digit 5, then pulse reset.
    for (int s = 0; s < 21; s++) step();
    check_vec("pre_rst_an", {24'h0, AN}, 32'hDF);
    check_vec("pre_rst_seg", {24'h0, SEG}, 32'hA4);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check_vec("mid_rst_an", {24'h0, AN}, 32'hFF);
    check_vec("mid_rst_seg", {24'h0, SEG}, 32'hFF);
    check_vec("mid_rst_fd", {31'h0, frame_done}, 32'h0);
    step();
    check_vec("resume_an", {24'h0, AN}, 32'hFE);
    check_vec("resume_seg", {24'h0, SEG}, 32'hC0);
    for (int s = 0; s < 3; s++) step();
    check_vec("resume_d0_hold", {24'h0, AN}, 32'hFE);
    step();
`ifdef SEG7_LZ_BLANK_EN
    check_vec("resume_d1_an", {24'h0, AN}, 32'hFF);
    check_vec("resume_d1_seg", {24'h0, SEG}, 32'hFF);
`else
    check_vec("resume_d1_an", {24'h0, AN}, 32'hFD);
    check_vec("resume_d1_seg", {24'h0, SEG}, 32'hC0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
